// File: rtl/load_seq_pkg.sv
// Shared types and defaults for the preload sequencer and its FIFO.
package load_seq_pkg;

  typedef logic [3:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_TC = 2'd2
  } load_seq_state_e;

  localparam int    DEFAULT_DEPTH    = 4;
  localparam data_t DEFAULT_TC_VALUE = 4'hF;

endpackage

// File: rtl/load_fifo.sv
// Synchronous FIFO holding queued preload values; reports its fill level.
module load_fifo
  import load_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  data_t                  wr_data,
  input  logic                   pop,
  output data_t                  rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);

  data_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_en, rd_en;

  // Guard both ends so a misbehaving caller cannot corrupt the pointers.
  assign wr_en = push && (level_q != FULL_LVL);
  assign rd_en = pop && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/load_sequencer.sv
// Feeds queued preload values to a 4-bit loadable counter, replacing its
// natural wrap at TC_VALUE with the next queued value.
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int    DEPTH    = DEFAULT_DEPTH,
  parameter data_t TC_VALUE = DEFAULT_TC_VALUE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  data_t                  in_data,
  output logic                   in_ready,
  input  logic                   enable,
  input  data_t                  count,
  output logic                   load,
  output data_t                  load_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output load_seq_state_e        state_dbg
);

  // Handshake: a value is accepted on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on the registered level.

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW + 1)'(DEPTH);
  localparam data_t       TC_PREV   = data_t'(TC_VALUE - 4'd1);

  load_seq_state_e state_q, state_d;
  logic            load_q, load_d;
  data_t           load_data_q, load_data_d;
  data_t           head;
  logic            push;

  assign in_ready = (level < DEPTH_LVL);
  assign push     = in_valid && in_ready;

  // The entry is retired in the same cycle its load strobe is on the wire.
  load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_data),
    .pop     (load_q),
    .rd_data (head),
    .level   (level)
  );

  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    load_data_d = 4'h0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (level != '0)) begin
          state_d     = ST_ISSUE;
          load_d      = 1'b1;
          load_data_d = head;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_TC;
      ST_WAIT_TC: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count == TC_PREV) begin
          if (level != '0) begin
            state_d     = ST_ISSUE;
            load_d      = 1'b1;
            load_data_d = head;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_q      <= 1'b0;
      load_data_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      load_data_q <= load_data_d;
    end
  end

  assign load      = load_q;
  assign load_data = load_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer driving a modelled 4-bit loadable counter.
module tb_load_sequencer;
  import load_seq_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  data_t           in_data = 4'h0;
  logic            in_ready;
  logic            enable = 1'b0;
  data_t           cnt = 4'h0;
  logic            load;
  data_t           load_data;
  logic            busy;
  logic [2:0]      level;
  load_seq_state_e state_dbg;

  logic            cnt_run = 1'b0;
  logic            cnt_force = 1'b0;
  data_t           cnt_force_val = 4'h0;

  int vectors = 0;
  int errors  = 0;

  load_sequencer #(.DEPTH(4), .TC_VALUE(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .enable    (enable),
    .count     (cnt),
    .load      (load),
    .load_data (load_data),
    .busy      (busy),
    .level     (level),
    .state_dbg (state_dbg)
  );

  // Clock and downstream counter model.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_force)    cnt <= cnt_force_val;
    else if (load)    cnt <= load_data;
    else if (cnt_run) cnt <= cnt + 4'h1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input data_t v);
    int n = 0;
    while (cnt !== v && n < 40) begin
      tick();
      n++;
    end
    check("wait_cnt", 32'(n < 40), 32'd1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_ldata", 32'(load_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;

    // Basic issue: push 7, load one cycle later (no bypass)
    cnt_force = 1'b1; cnt_force_val = 4'h0;
    tick();
    cnt_force = 1'b0;
    enable = 1'b1; in_valid = 1'b1; in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    check("b_level1", 32'(level), 32'd1);
    check("b_nobypass", 32'(load), 32'd0);
    tick();
    check("b_load", 32'(load), 32'd1);
    check("b_ldata", 32'(load_data), 32'h7);
    check("b_busy", 32'(busy), 32'd1);
    tick();
    check("b_load_off", 32'(load), 32'd0);
    check("b_ldata_off", 32'(load_data), 32'd0);
    check("b_level0", 32'(level), 32'd0);
    check("b_wait", 32'(state_dbg), 32'(ST_WAIT_TC));
    check("b_cnt7", 32'(cnt), 32'h7);

    // Empty at terminal: return to IDLE, counter wraps naturally
    cnt_run = 1'b1;
    wait_cnt(4'hE);
    check("e_wait", 32'(state_dbg), 32'(ST_WAIT_TC));
    tick();
    check("e_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("e_busy", 32'(busy), 32'd0);
    check("e_cntF", 32'(cnt), 32'hF);
    tick();
    check("e_cnt0", 32'(cnt), 32'h0);
    check("e_noload", 32'(load), 32'd0);
    cnt_run = 1'b0;

    // Chained preload: 7 then 5, second load replaces the wrap
    in_valid = 1'b1; in_data = 4'h7;
    tick();
    check("c_level1", 32'(level), 32'd1);
    in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    check("c_level2", 32'(level), 32'd2);
    check("c_load1", 32'(load), 32'd1);
    check("c_ldata1", 32'(load_data), 32'h7);
    tick();
    check("c_level_pop", 32'(level), 32'd1);
    check("c_cnt7", 32'(cnt), 32'h7);
    cnt_run = 1'b1;
    wait_cnt(4'hE);
    check("c_noearly", 32'(load), 32'd0);
    tick();
    check("c_cntF", 32'(cnt), 32'hF);
    check("c_load2", 32'(load), 32'd1);
    check("c_ldata2", 32'(load_data), 32'h5);
    tick();
    check("c_cnt5", 32'(cnt), 32'h5);
    check("c_load2_off", 32'(load), 32'd0);
    check("c_level0", 32'(level), 32'd0);
    enable = 1'b0; cnt_run = 1'b0;
    tick();
    check("c_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Full FIFO with enable low
    in_valid = 1'b1;
    in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h3; tick();
    in_data = 4'h4; tick();
    check("f_level4", 32'(level), 32'd4);
    check("f_ready0", 32'(in_ready), 32'd0);
    in_data = 4'h9;
    tick();
    check("f_level_hold", 32'(level), 32'd4);
    enable = 1'b1;
    tick();
    check("f_load", 32'(load), 32'd1);
    check("f_ldata1", 32'(load_data), 32'h1);
    check("f_nowt", 32'(level), 32'd4);
    check("f_ready_issue", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("f_level3", 32'(level), 32'd3);
    check("f_ready1", 32'(in_ready), 32'd1);

    // Next entry issued at terminal count, then enable drop with 2 queued
    cnt_force = 1'b1; cnt_force_val = 4'hE;
    tick();
    cnt_force = 1'b0;
    check("d_cntE", 32'(cnt), 32'hE);
    tick();
    check("d_load", 32'(load), 32'd1);
    check("d_ldata2", 32'(load_data), 32'h2);
    tick();
    check("d_level2", 32'(level), 32'd2);
    enable = 1'b0;
    tick();
    check("d_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("d_busy0", 32'(busy), 32'd0);
    check("d_level_keep", 32'(level), 32'd2);
    cnt_force = 1'b1; cnt_force_val = 4'hE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d_noload", 32'(load), 32'd0);
    end
    cnt_force = 1'b0;
    check("d_level_still", 32'(level), 32'd2);
    enable = 1'b1;
    tick();
    check("d_load3", 32'(load), 32'd1);
    check("d_ldata3", 32'(load_data), 32'h3);
    tick();
    check("d_level1", 32'(level), 32'd1);
    check("d_cnt3", 32'(cnt), 32'h3);

    // Reset mid-stream with 3 entries queued
    in_valid = 1'b1; in_data = 4'h6;
    tick();
    in_data = 4'h8;
    tick();
    in_valid = 1'b0;
    check("r_level3", 32'(level), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("r_level0", 32'(level), 32'd0);
    check("r_load0", 32'(load), 32'd0);
    check("r_ready1", 32'(in_ready), 32'd1);
    check("r_busy0", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    cnt_force = 1'b1; cnt_force_val = 4'hE;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r_noload", 32'(load), 32'd0);
    end
    cnt_force = 1'b0;
    check("r_idle", 32'(state_dbg), 32'(ST_IDLE));
    in_valid = 1'b1; in_data = 4'hA;
    tick();
    in_valid = 1'b0;
    tick();
    check("r_load_new", 32'(load), 32'd1);
    check("r_ldata_new", 32'(load_data), 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, number of queued preload entries (power of 2, >=2).
REQ-002 Parameter TC_VALUE, default 4'hF, count value at which the next queued preload replaces the counter's natural wrap.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream preload value offered.
REQ-006 in_data  input  4  preload value.
REQ-007 in_ready  output  1  sequencer can accept a value this cycle.
REQ-008 enable  input  1  sequencing permitted.
REQ-009 count  input  4  current count fed back from the downstream 4-bit loadable counter.
REQ-010 load  output  1  one-cycle load strobe to the counter.
REQ-011 load_data  output  4  value to load; valid while load=1.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 level  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-014 A push occurs on a rising edge when in_valid=1 and in_ready=1; the value is appended to the FIFO tail.
REQ-015 in_ready shall equal (level < DEPTH), combinational from registered level only; no write-through when full, even on a same-cycle pop.
REQ-016 A pop occurs exactly in the cycle load=1; a simultaneous push and pop leaves level unchanged and preserves FIFO order.
REQ-017 FSM states: IDLE, ISSUE, WAIT_TC, all encoded in the shared package enum.
REQ-018 IDLE -> ISSUE when enable=1 and level>0; otherwise remain in IDLE.
REQ-019 ISSUE: load=1 and load_data=FIFO head for exactly one cycle, then -> WAIT_TC unconditionally.
REQ-020 WAIT_TC -> ISSUE when count==TC_VALUE-1 (mod 16) and enable=1 and level>0, so load is high while count==TC_VALUE and the counter loads instead of wrapping.
REQ-021 WAIT_TC -> IDLE when enable=0, or when count==TC_VALUE-1 with level==0; the counter then wraps naturally.
REQ-022 If count skips TC_VALUE-1 (external counter reset or load), the sequencer remains in WAIT_TC and keeps waiting.
REQ-023 load and load_data shall be registered outputs; load_data shall be 4'h0 whenever load=0.
REQ-024 A value pushed in the same cycle the FIFO is empty shall not be issued before the following cycle (no bypass).
REQ-025 Deasserting enable never aborts an ISSUE cycle already in progress.

Reset
REQ-026 While reset=1: state=IDLE, FIFO empty, level=0, load=0, load_data=4'h0, busy=0, in_ready=1.
REQ-027 Reset asserted mid-operation discards all queued entries immediately; no load pulse shall follow reset release until a new push.
REQ-028 Reset deassertion is assumed synchronised externally; first state change occurs at the first rising edge after release.

Structure
REQ-029 A shared package load_seq_pkg shall hold the state enum typedef, DEPTH and TC_VALUE defaults, and the 4-bit data typedef.
REQ-030 FIFO storage and pointers shall be a separate sub-module load_fifo (synchronous, DEPTH entries, level output); the FSM lives in load_sequencer.

Verification
REQ-031 Reset check: assert reset mid-stream with 3 entries queued -> level=0, load=0, in_ready=1 in the same cycle; no load after release.
REQ-032 Basic issue: push 4'h7, enable=1 -> load=1 with load_data=4'h7 for exactly one cycle two edges after push; busy=1 thereafter.
REQ-033 Chained preload: queue 4'h7 then 4'h5, counter running -> second load pulse coincides with count=4'hF, counter next shows 4'h5, never 4'h0.
REQ-034 Full FIFO: push 4 values with enable=0 -> level=4, in_ready=0; a 5th in_valid is not accepted; first pop restores in_ready next cycle.
REQ-035 Empty at terminal: single entry issued, no further pushes -> at count=4'hE FSM returns to IDLE, busy=0, counter wraps 4'hF->4'h0.
REQ-036 Enable drop: deassert enable in WAIT_TC with 2 entries queued -> IDLE next cycle, level stays 2, no load until enable returns.
